// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared NPCOp encodings, fetch state encoding and constants for the fetch stage.
package if_fetch_unit_pkg;

    localparam logic [2:0]  NPC_PLUS4  = 3'b000;
    localparam logic [2:0]  NPC_BRANCH = 3'b001;
    localparam logic [2:0]  NPC_JUMP   = 3'b010;
    localparam logic [2:0]  NPC_JALR   = 3'b100;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// npc_calc: combinational redirect target (word aligned) and misalignment flag from the NPCOp encoding.
module npc_calc
    import if_fetch_unit_pkg::*;
(
    input  logic [2:0]  npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_aluout,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] raw;

    // Unknown encodings fall back to the sequential +4 path.
    always_comb begin
        raw = (npc_op == NPC_BRANCH || npc_op == NPC_JUMP) ? ex_pc + ex_imm :
              (npc_op == NPC_JALR) ? {ex_aluout[31:1], 1'b0} : ex_pc + 32'd4;
    end

    assign target   = {raw[31:2], 2'b00};
    assign misalign = raw[1];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, single-outstanding imem fetch handshake and one-entry decode buffer
// with execute-stage redirects that flush the buffer and drop any in-flight response.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            ex_redirect,
    input  logic [2:0]      NPCOp,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_aluout,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            misalign_err
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, id_instr_n, id_pc_n, tgt;
    logic            drop, drop_n, id_valid_n, misalign_n, tgt_mis, accept;

    npc_calc u_npc_calc (
        .npc_op   (NPCOp),
        .ex_pc    (ex_pc),
        .ex_imm   (ex_imm),
        .ex_aluout(ex_aluout),
        .target   (tgt),
        .misalign (tgt_mis)
    );

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = {pc[XLEN-1:2], 2'b00};
    assign accept         = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            drop         <= 1'b0;
            id_valid     <= 1'b0;
            id_instr     <= NOP_INSTR;
            id_pc        <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            drop         <= drop_n;
            id_valid     <= id_valid_n;
            id_instr     <= id_instr_n;
            id_pc        <= id_pc_n;
            misalign_err <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        id_valid_n = id_valid;
        id_instr_n = id_instr;
        id_pc_n    = id_pc;
        misalign_n = misalign_err;
        if (ex_redirect) begin
            pc_n       = tgt;
            id_valid_n = 1'b0;
            misalign_n = misalign_err | tgt_mis;
            // A request accepted on the redirect edge is still in flight and must be discarded.
            unique case (state)
                S_REQ: begin
                    state_n = accept ? S_WAIT : S_REQ;
                    drop_n  = accept;
                end
                S_WAIT: begin
                    state_n = imem_rsp_valid ? S_REQ : S_WAIT;
                    drop_n  = !imem_rsp_valid;
                end
                default: state_n = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ:  state_n = accept ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rsp_valid && drop) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else if (imem_rsp_valid) begin
                        id_instr_n = imem_rdata;
                        id_pc_n    = pc;
                        id_valid_n = 1'b1;
                        pc_n       = pc + 32'd4;
                        state_n    = S_FULL;
                    end
                end
                S_FULL: begin
                    id_valid_n = id_ready ? 1'b0 : 1'b1;
                    state_n    = id_ready ? S_REQ : S_FULL;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of the fetch stage against a transaction-level model
// (next fetch address, one outstanding read with a stale flag, one-entry buffer).
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        ex_redirect = 1'b0;
    logic [2:0]  NPCOp = 3'b000;
    logic [31:0] ex_pc = 32'h0, ex_imm = 32'h0, ex_aluout = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr, id_pc;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .ex_redirect(ex_redirect), .NPCOp(NPCOp), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_aluout(ex_aluout),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .misalign_err(misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] redirect_target(input logic [2:0] op, input logic [31:0] pc,
                                                     input logic [31:0] imm, input logic [31:0] alu);
        if (op == 3'b001 || op == 3'b010) return pc + imm;
        if (op == 3'b100) return alu & 32'hFFFF_FFFE;
        return pc + 32'd4;
    endfunction

    // Instruction memory: answers each accepted request after a programmable latency.
    logic        rsp_pend = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;
    int          mem_lat = 0;
    bit          lat_rand = 1'b0;
    bit          inj_rsp = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) rsp_pend = 1'b0;
        else if (imem_req_valid && imem_req_ready) begin
            rsp_pend = 1'b1;
            rsp_addr = imem_addr;
            rsp_cnt  = lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
        end
    end

    always @(negedge clk) begin
        #1;
        imem_rsp_valid = inj_rsp;
        if (inj_rsp) imem_rdata = 32'hDEAD_BEEF;
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = mem_word(rsp_addr);
                rsp_pend       = 1'b0;
            end else rsp_cnt--;
        end
    end

    // Reference model, advanced once per rising edge from the pre-edge inputs.
    logic        m_started, m_out, m_stale, m_bv, m_mis;
    logic [31:0] m_pc, m_out_addr, m_bpc, m_binstr;
    logic        m_req;
    assign m_req = m_started && !m_out && !m_bv;

    always @(posedge clk or negedge rstn) begin
        logic acc, rsp;
        logic [31:0] t;
        if (!rstn) begin
            m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_mis = 1'b0;
            m_pc = RESET_PC; m_out_addr = RESET_PC; m_bpc = 32'h0; m_binstr = NOP_INSTR;
        end else begin
            acc = m_started && !m_out && !m_bv && imem_req_ready;
            rsp = m_out && imem_rsp_valid;
            if (ex_redirect) begin
                t     = redirect_target(NPCOp, ex_pc, ex_imm, ex_aluout);
                m_mis = m_mis | t[1];
                m_pc  = {t[31:2], 2'b00};
                m_bv  = 1'b0;
                if (rsp) m_out = 1'b0;
                else if (m_out) m_stale = 1'b1;
                if (acc) begin m_out = 1'b1; m_stale = 1'b1; end
            end else begin
                if (acc) begin m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc; end
                if (rsp) begin
                    m_out = 1'b0;
                    if (!m_stale) begin
                        m_bv = 1'b1; m_bpc = m_out_addr; m_binstr = imem_rdata; m_pc = m_pc + 32'd4;
                    end
                    m_stale = 1'b0;
                end else if (m_bv && id_ready) m_bv = 1'b0;
            end
            m_started = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_id(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) if (id_valid) ok = 1'b1; else tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) if (imem_req_valid) ok = 1'b1; else tick();
    endtask

    task automatic redirect(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] alu);
        ex_redirect = 1'b1; NPCOp = op; ex_pc = pc; ex_imm = imm; ex_aluout = alu;
        tick();
        ex_redirect = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        n_cmp++; if (id_instr !== NOP_INSTR) begin n_err++; $display("FAIL reset_id_instr: got %h expected %h", id_instr, NOP_INSTR); end
        n_cmp++; if (id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
        imem_req_ready = 1'b1; id_ready = 1'b1; mem_lat = 0;
        rstn = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_req: got %b expected 0", imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        logic [31:0] pres[$];
        for (int k = 0; k < 40 && (addrs.size() < 3 || pres.size() < 2); k++) begin
            tick();
            if (imem_req_valid && imem_req_ready) addrs.push_back(imem_addr);
            if (id_valid) begin
                pres.push_back(id_pc);
                n_cmp++; if (id_instr !== mem_word(id_pc)) begin n_err++; $display("FAIL seq_instr: got %h expected %h", id_instr, mem_word(id_pc)); end
            end
        end
        n_cmp++; if (addrs.size() < 3 || pres.size() < 2) begin n_err++; $display("FAIL seq_timeout: got %0d/%0d expected 3/2", addrs.size(), pres.size()); end
        for (int i = 0; i < 3 && i < addrs.size(); i++) begin
            n_cmp++; if (addrs[i] !== 32'(i * 4)) begin n_err++; $display("FAIL seq_addr%0d: got %h expected %h", i, addrs[i], i * 4); end
        end
        for (int i = 0; i < pres.size() && i < addrs.size(); i++) begin
            n_cmp++; if (pres[i] !== addrs[i]) begin n_err++; $display("FAIL seq_id_pc%0d: got %h expected %h", i, pres[i], addrs[i]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] p, ins;
        id_ready = 1'b0;
        wait_id(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout: got 0 expected 1"); end
        p = id_pc; ins = id_instr;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== p || id_instr !== ins || imem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: got v=%b pc=%h ins=%h req=%b expected v=1 pc=%h ins=%h req=0", id_valid, id_pc, id_instr, imem_req_valid, p, ins);
            end
        end
        id_ready = 1'b1;
        tick();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== p + 32'd4) begin
            n_err++; $display("FAIL stall_next_addr: got req=%b addr=%h expected req=1 addr=%h", imem_req_valid, imem_addr, p + 32'd4);
        end
    endtask

    task automatic test_branch();
        bit ok;
        id_ready = 1'b0;
        wait_id(ok);
        redirect(3'b001, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL br_flush: got %b expected 0", id_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_00F0) begin
            n_err++; $display("FAIL br_addr: got req=%b addr=%h expected req=1 addr=000000f0", imem_req_valid, imem_addr);
        end
        wait_id(ok);
        n_cmp++; if (!ok || id_pc !== 32'h0000_00F0 || id_instr !== mem_word(32'hF0)) begin
            n_err++; $display("FAIL br_fetch: got pc=%h ins=%h expected pc=000000f0 ins=%h", id_pc, id_instr, mem_word(32'hF0));
        end
    endtask

    task automatic test_jalr_wait();
        bit ok;
        id_ready = 1'b1; mem_lat = 3;
        tick();
        wait_req(ok);
        tick();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL jalr_in_wait: got req=%b expected 0", imem_req_valid); end
        redirect(3'b100, 32'h0000_0040, 32'h0000_0010, 32'h0000_0203);
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL jalr_misalign: got %b expected 1", misalign_err); end
        for (int k = 0; k < 20 && !imem_req_valid; k++) begin
            n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL jalr_discard: got id_valid=%b id_instr=%h expected 0", id_valid, id_instr); end
            tick();
        end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            n_err++; $display("FAIL jalr_addr: got req=%b addr=%h expected req=1 addr=00000200", imem_req_valid, imem_addr);
        end
        wait_id(ok);
        n_cmp++; if (!ok || id_pc !== 32'h0000_0200 || id_instr !== mem_word(32'h200)) begin
            n_err++; $display("FAIL jalr_fetch: got pc=%h ins=%h expected pc=00000200 ins=%h", id_pc, id_instr, mem_word(32'h200));
        end
        mem_lat = 0;
    endtask

    task automatic test_wrap_same_edge();
        bit ok;
        id_ready = 1'b0;
        wait_id(ok);
        id_ready = 1'b1;
        redirect(3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0);
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL wrap_flush: got %b expected 0", id_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0004) begin
            n_err++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=00000004", imem_req_valid, imem_addr);
        end
        wait_id(ok);
        n_cmp++; if (!ok || id_pc !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_next_pc: got %h expected 00000004", id_pc); end
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_sticky: got %b expected 1", misalign_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        id_ready = 1'b1; mem_lat = 3;
        tick();
        wait_req(ok);
        tick();
        #2 rstn = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || misalign_err !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_clear: got v=%b mis=%b req=%b expected 0 0 0", id_valid, misalign_err, imem_req_valid);
        end
        tick(); tick();
        rstn = 1'b1; inj_rsp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
                n_err++; $display("FAIL rst_mid_ignore%0d: got v=%b req=%b addr=%h expected v=0 req=1 addr=%h", k, id_valid, imem_req_valid, imem_addr, RESET_PC);
            end
        end
        inj_rsp = 1'b0; imem_req_ready = 1'b1; mem_lat = 0;
        wait_id(ok);
        n_cmp++; if (!ok || id_pc !== RESET_PC || id_instr !== mem_word(RESET_PC)) begin
            n_err++; $display("FAIL rst_mid_refetch: got pc=%h ins=%h expected pc=%h ins=%h", id_pc, id_instr, RESET_PC, mem_word(RESET_PC));
        end
    endtask

    task automatic test_random();
        lat_rand = 1'b1;
        for (int k = 0; k < 800; k++) begin
            tick();
            n_cmp++; if (imem_req_valid !== m_req || (m_req && imem_addr !== m_pc)) begin
                n_err++; $display("FAIL rnd_req@%0d: got req=%b addr=%h expected req=%b addr=%h", k, imem_req_valid, imem_addr, m_req, m_pc);
            end
            n_cmp++; if (id_valid !== m_bv || (m_bv && (id_pc !== m_bpc || id_instr !== m_binstr))) begin
                n_err++; $display("FAIL rnd_buf@%0d: got v=%b pc=%h ins=%h expected v=%b pc=%h ins=%h", k, id_valid, id_pc, id_instr, m_bv, m_bpc, m_binstr);
            end
            n_cmp++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_misalign@%0d: got %b expected %b", k, misalign_err, m_mis); end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = $urandom_range(0, 1) == 1;
            ex_redirect    = ($urandom_range(0, 11) == 0);
            NPCOp          = 3'($urandom_range(0, 7));
            ex_pc          = $urandom;
            ex_imm         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            ex_aluout      = $urandom;
        end
        ex_redirect = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jalr_wait();
        test_wrap_same_edge();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
